// File: rtl/sprite_engine_pkg.sv
// Shared register map, CTRL bit positions and slot register layout
// for the sprite engine.
package sprite_engine_pkg;

  localparam logic [1:0] OFF_X    = 2'd0;
  localparam logic [1:0] OFF_Y    = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_ANIM = 1;
  localparam int CTRL_FLSB = 4;
  localparam int CTRL_FMSB = 7;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        en;
    logic        anim;
    logic [3:0]  frm;
  } spr_regs_t;

  function automatic logic [15:0] ctrl_word(input spr_regs_t r);
    return {8'h00, r.frm, 2'b00, r.anim, r.en};
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: pending/active registers, animation divider,
// ROM base address and line-start compare.
module sprite_slot
  import sprite_engine_pkg::*;
#(
  parameter int CORDW      = 16,
  parameter int NUM_FRAMES = 3,
  parameter int SPR_PIXELS = 640,
  parameter int ADDRW      = 11,
  parameter int ANIM_DIV   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_x_i,
  input  logic                    wr_y_i,
  input  logic                    wr_ctrl_i,
  input  logic [15:0]             wdata_i,
  input  logic                    frame_i,
  input  logic                    line_i,
  input  logic signed [CORDW-1:0] sy_i,
  output spr_regs_t               pend_o,
  output logic [3:0]              frm_o,
  output logic signed [CORDW-1:0] x_o,
  output logic                    start_o,
  output logic                    en_o,
  output logic [ADDRW-1:0]        base_o
);

  localparam logic [3:0] FRM_MAX = 4'(NUM_FRAMES - 1);

  spr_regs_t pend_q, pend_d;
  spr_regs_t act_q, act_d;
  logic [ADDRW-1:0] base_q;
  logic start_q;
  logic [3:0] wfrm;
  logic signed [CORDW-1:0] y_s;
  logic hit;

  always_comb begin
    wfrm = wdata_i[CTRL_FMSB:CTRL_FLSB];
    if (wfrm > FRM_MAX) wfrm = FRM_MAX;
  end

  always_comb begin
    pend_d = pend_q;
    if (wr_x_i) pend_d.x = wdata_i;
    if (wr_y_i) pend_d.y = wdata_i;
    if (wr_ctrl_i) begin
      pend_d.en  = wdata_i[CTRL_EN];
`ifdef SPRITE_AUTOANIM_EN
      pend_d.anim = wdata_i[CTRL_ANIM];
`else
      pend_d.anim = 1'b0;
`endif
      pend_d.frm = wfrm;
    end
  end

`ifdef SPRITE_AUTOANIM_EN
  localparam int DIVW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_TC = DIVW'(ANIM_DIV - 1);

  logic [DIVW-1:0] div_q, div_d;
  logic ld_q, ld_d;
  logic adv;
  logic [3:0] nxt_frm;

  assign nxt_frm = (act_q.frm == FRM_MAX) ? 4'd0 : act_q.frm + 4'd1;

  // A CPU frame write overrides animation until it has been committed
  always_comb begin
    ld_d  = ld_q;
    div_d = div_q;
    adv   = 1'b0;
    if (frame_i) ld_d = 1'b0;
    if (frame_i && act_q.anim) begin
      if (div_q == DIV_TC) begin
        div_d = '0;
        adv   = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (wr_ctrl_i) begin
      ld_d  = 1'b1;
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ld_q  <= ld_d;
    end
  end
`else
  logic [32:0] unused_cfg;
  assign unused_cfg = {act_q.anim, 32'(ANIM_DIV)};
`endif

  always_comb begin
    act_d = act_q;
    if (frame_i) begin
      act_d = pend_q;
`ifdef SPRITE_AUTOANIM_EN
      if (!ld_q) act_d.frm = adv ? nxt_frm : act_q.frm;
`endif
    end
  end

  assign y_s = CORDW'(signed'(act_q.y));
  assign hit = act_q.en && !y_s[CORDW-1] && (y_s == sy_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      act_q   <= '0;
      base_q  <= '0;
      start_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      base_q  <= ADDRW'(32'(act_q.frm) * 32'(SPR_PIXELS));
      start_q <= line_i && hit;
    end
  end

  assign pend_o  = pend_q;
  assign frm_o   = act_q.frm;
  assign x_o     = CORDW'(signed'(act_q.x));
  assign start_o = start_q;
  assign en_o    = act_q.en;
  assign base_o  = base_q;

endmodule

// File: rtl/sprite_engine.sv
// Sprite engine top: CPU bus decode, read mux and per-slot instances.
// Optional feature macro: SPRITE_AUTOANIM_EN (frame auto-animation).
module sprite_engine
  import sprite_engine_pkg::*;
#(
  parameter int NUM_SPR    = 4,
  parameter int CORDW      = 16,
  parameter int NUM_FRAMES = 3,
  parameter int SPR_PIXELS = 640,
  parameter int ADDRW      = 11,
  parameter int ANIM_DIV   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 bus_cs,
  input  logic                                 bus_write,
  input  logic [7:0]                           bus_addr,
  input  logic [15:0]                          bus_wdata,
  output logic [15:0]                          bus_rdata,
  input  logic                                 frame,
  input  logic                                 line,
  input  logic signed [CORDW-1:0]              sy,
  output logic signed [NUM_SPR-1:0][CORDW-1:0] spr_x,
  output logic [NUM_SPR-1:0]                   spr_start,
  output logic [NUM_SPR-1:0]                   spr_en,
  output logic [NUM_SPR-1:0][ADDRW-1:0]        spr_base
);

  logic [5:0] slot;
  logic [1:0] off;
  logic wr;
  logic [15:0] rdata_q, rdata_d;
  spr_regs_t pend [NUM_SPR];
  logic [3:0] frm [NUM_SPR];

  assign slot = bus_addr[7:2];
  assign off  = bus_addr[1:0];
  assign wr   = bus_cs && bus_write;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
    logic sel;
    assign sel = wr && (slot == 6'(i));

    sprite_slot #(
      .CORDW     (CORDW),
      .NUM_FRAMES(NUM_FRAMES),
      .SPR_PIXELS(SPR_PIXELS),
      .ADDRW     (ADDRW),
      .ANIM_DIV  (ANIM_DIV)
    ) u_slot (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_x_i   (sel && off == OFF_X),
      .wr_y_i   (sel && off == OFF_Y),
      .wr_ctrl_i(sel && off == OFF_CTRL),
      .wdata_i  (bus_wdata),
      .frame_i  (frame),
      .line_i   (line),
      .sy_i     (sy),
      .pend_o   (pend[i]),
      .frm_o    (frm[i]),
      .x_o      (spr_x[i]),
      .start_o  (spr_start[i]),
      .en_o     (spr_en[i]),
      .base_o   (spr_base[i])
    );
  end

  // Unmapped slots never match the loop and so read as zero
  always_comb begin
    rdata_d = rdata_q;
    if (bus_cs && !bus_write) begin
      rdata_d = '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        if (slot == 6'(i)) begin
          unique case (1'b1)
            off == OFF_X:    rdata_d = pend[i].x;
            off == OFF_Y:    rdata_d = pend[i].y;
            off == OFF_CTRL: rdata_d = ctrl_word(pend[i]);
            off == OFF_STAT: rdata_d = {12'h000, frm[i]};
            default:         rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed, table-driven bench for sprite_engine.
// Autoanim checks run only when SPRITE_AUTOANIM_EN is defined.
module tb_sprite_engine;

  localparam int NS = 4;
  localparam int CW = 16;
  localparam int AW = 11;

  localparam int OP_WR  = 0;
  localparam int OP_RD  = 1;
  localparam int OP_FR  = 2;
  localparam int OP_LN  = 3;
  localparam int OP_ID  = 4;
  localparam int OP_WRF = 5;

  localparam int CK_NONE = 0;
  localparam int CK_RD   = 1;
  localparam int CK_X    = 2;
  localparam int CK_ST   = 3;
  localparam int CK_EN   = 4;
  localparam int CK_BASE = 5;

  typedef struct {
    int          op;
    logic [7:0]  a;
    logic [15:0] d;
    int          ck;
    int          s;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic bus_cs, bus_write;
  logic [7:0] bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic frame, line;
  logic signed [CW-1:0] sy;
  logic signed [NS-1:0][CW-1:0] spr_x;
  logic [NS-1:0] spr_start, spr_en;
  logic [NS-1:0][AW-1:0] spr_base;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  sprite_engine #(
    .NUM_SPR(NS), .CORDW(CW), .NUM_FRAMES(3),
    .SPR_PIXELS(640), .ADDRW(AW), .ANIM_DIV(2)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_cs(bus_cs), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .frame(frame), .line(line), .sy(sy),
    .spr_x(spr_x), .spr_start(spr_start),
    .spr_en(spr_en), .spr_base(spr_base)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int op, input logic [7:0] a,
                       input logic [15:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_wdata = d;
    bus_cs    = (op == OP_WR) || (op == OP_RD) || (op == OP_WRF);
    bus_write = (op == OP_WR) || (op == OP_WRF);
    frame     = (op == OP_FR) || (op == OP_WRF);
    line      = (op == OP_LN);
    if (op == OP_LN) sy = d;
    @(posedge clk);
    #1;
    bus_cs = 1'b0; bus_write = 1'b0;
    frame  = 1'b0; line = 1'b0;
  endtask

  function automatic logic [31:0] actual(input int ck, input int s);
    case (ck)
      CK_RD:   return 32'(bus_rdata);
      CK_X:    return 32'(spr_x[s]);
      CK_ST:   return 32'(spr_start);
      CK_EN:   return 32'(spr_en);
      CK_BASE: return 32'(spr_base[s]);
      default: return 32'hdead_beef;
    endcase
  endfunction

  initial begin
    rst = 1'b1; bus_cs = 1'b0; bus_write = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    frame = 1'b0; line = 1'b0; sy = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_x", 32'(spr_x), 32'd0);
    check("rst_en", 32'(spr_en), 32'd0);
    check("rst_base", 32'(spr_base), 32'd0);
    check("rst_rdata", 32'(bus_rdata), 32'd0);

    vq.push_back('{OP_WR,  8'h00, 16'd100,  CK_X,    0, 32'd0,    "x_no_frame"});
    vq.push_back('{OP_ID,  8'h00, 16'd0,    CK_X,    0, 32'd0,    "x_still_0"});
    vq.push_back('{OP_RD,  8'h00, 16'd0,    CK_RD,   0, 32'd100,  "rd_x_pend"});
    vq.push_back('{OP_FR,  8'h00, 16'd0,    CK_X,    0, 32'd100,  "x_commit"});
    vq.push_back('{OP_WR,  8'h05, 16'd50,   CK_EN,   0, 32'h0,    "en_pre"});
    vq.push_back('{OP_WR,  8'h06, 16'h0001, CK_EN,   0, 32'h0,    "en_pend"});
    vq.push_back('{OP_FR,  8'h00, 16'd0,    CK_EN,   0, 32'h2,    "en_commit"});
    vq.push_back('{OP_LN,  8'h00, 16'd50,   CK_ST,   0, 32'h2,    "start_y50"});
    vq.push_back('{OP_ID,  8'h00, 16'd0,    CK_ST,   0, 32'h0,    "start_once"});
    vq.push_back('{OP_LN,  8'h00, 16'd51,   CK_ST,   0, 32'h0,    "start_y51"});
    vq.push_back('{OP_WR,  8'h0A, 16'h0091, CK_NONE, 0, 32'h0,    "ctrl2_wr"});
    vq.push_back('{OP_RD,  8'h0A, 16'd0,    CK_RD,   0, 32'h0021, "ctrl_clamp"});
    vq.push_back('{OP_FR,  8'h00, 16'd0,    CK_EN,   0, 32'h6,    "en_two"});
    vq.push_back('{OP_RD,  8'h0B, 16'd0,    CK_RD,   0, 32'd2,    "stat_frm"});
    vq.push_back('{OP_ID,  8'h00, 16'd0,    CK_BASE, 2, 32'd1280, "base_frm2"});
    vq.push_back('{OP_WR,  8'h0D, 16'hFFFB, CK_NONE, 0, 32'h0,    "y3_neg"});
    vq.push_back('{OP_WR,  8'h0E, 16'h0001, CK_NONE, 0, 32'h0,    "ctrl3_en"});
    vq.push_back('{OP_FR,  8'h00, 16'd0,    CK_EN,   0, 32'hE,    "en_three"});
    vq.push_back('{OP_LN,  8'h00, 16'hFFFB, CK_ST,   0, 32'h0,    "neg_y"});
    vq.push_back('{OP_LN,  8'h00, 16'd0,    CK_ST,   0, 32'h4,    "y0_dis_en"});
    vq.push_back('{OP_WR,  8'h24, 16'h1234, CK_NONE, 0, 32'h0,    "wr_unmap"});
    vq.push_back('{OP_RD,  8'h24, 16'd0,    CK_RD,   0, 32'h0,    "rd_unmap"});
    vq.push_back('{OP_WR,  8'h03, 16'h0005, CK_NONE, 0, 32'h0,    "wr_stat"});
    vq.push_back('{OP_RD,  8'h03, 16'd0,    CK_RD,   0, 32'h0,    "stat_ro"});
    vq.push_back('{OP_WRF, 8'h05, 16'd30,   CK_NONE, 0, 32'h0,    "wr_on_frame"});
    vq.push_back('{OP_LN,  8'h00, 16'd50,   CK_ST,   0, 32'h2,    "old_y_act"});
    vq.push_back('{OP_LN,  8'h00, 16'd30,   CK_ST,   0, 32'h0,    "new_y_pend"});
    vq.push_back('{OP_FR,  8'h00, 16'd0,    CK_NONE, 0, 32'h0,    "frame_y30"});
    vq.push_back('{OP_LN,  8'h00, 16'd30,   CK_ST,   0, 32'h2,    "new_y_act"});
    vq.push_back('{OP_RD,  8'h05, 16'd0,    CK_RD,   0, 32'd30,   "rd_y30"});

    foreach (vq[k]) begin
      drive(vq[k].op, vq[k].a, vq[k].d);
      if (vq[k].ck != CK_NONE)
        check(vq[k].nm, actual(vq[k].ck, vq[k].s), vq[k].exp);
    end

`ifdef SPRITE_AUTOANIM_EN
    begin
      logic [31:0] seq [7];
      seq = '{32'd0, 32'd0, 32'd640, 32'd640, 32'd1280, 32'd1280, 32'd0};
      drive(OP_WR, 8'h02, 16'h0003);
      drive(OP_RD, 8'h02, 16'h0);
      check("ctrl_anim_rd", 32'(bus_rdata), 32'h0003);
      for (int f = 0; f < 7; f++) begin
        drive(OP_FR, 8'h00, 16'h0);
        drive(OP_ID, 8'h00, 16'h0);
        check($sformatf("anim_f%0d", f + 1), 32'(spr_base[0]), seq[f]);
      end
      drive(OP_WR, 8'h02, 16'h0023);
      drive(OP_FR, 8'h00, 16'h0);
      drive(OP_ID, 8'h00, 16'h0);
      check("anim_cpu_frm", 32'(spr_base[0]), 32'd1280);
    end
`else
    drive(OP_WR, 8'h02, 16'h0003);
    drive(OP_RD, 8'h02, 16'h0);
    check("anim_reserved", 32'(bus_rdata), 32'h0001);
    for (int f = 0; f < 3; f++) begin
      drive(OP_FR, 8'h00, 16'h0);
      drive(OP_ID, 8'h00, 16'h0);
      check($sformatf("no_anim_f%0d", f + 1), 32'(spr_base[0]), 32'd0);
    end
`endif

    drive(OP_WR, 8'h04, 16'd77);
    drive(OP_RD, 8'h05, 16'h0);
    check("rd_before_rst", 32'(bus_rdata), 32'd30);
    @(negedge clk);
    rst = 1'b1;
    bus_cs = 1'b1; bus_write = 1'b1;
    bus_addr = 8'h00; bus_wdata = 16'd55;
    frame = 1'b1; line = 1'b1; sy = 16'd30;
    @(posedge clk);
    #1;
    rst = 1'b0; bus_cs = 1'b0; bus_write = 1'b0;
    frame = 1'b0; line = 1'b0;
    check("rst2_x", 32'(spr_x), 32'd0);
    check("rst2_en", 32'(spr_en), 32'd0);
    check("rst2_start", 32'(spr_start), 32'd0);
    check("rst2_base", 32'(spr_base), 32'd0);
    check("rst2_rdata", 32'(bus_rdata), 32'd0);
    drive(OP_RD, 8'h24, 16'h0);
    check("rd_slot9", 32'(bus_rdata), 32'd0);
    drive(OP_FR, 8'h00, 16'h0);
    check("rst_pend_x1", 32'(spr_x[1]), 32'd0);
    check("rst_lost_wr", 32'(spr_x[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 SHALL have parameter NUM_SPR, default 4, number of sprite slots (1..16).
REQ-002 SHALL have parameter CORDW, default 16, signed coordinate width.
REQ-003 SHALL have parameter NUM_FRAMES, default 3, animation frames per sprite (1..16).
REQ-004 SHALL have parameter SPR_PIXELS, default 640, pixels per frame in graphic ROM.
REQ-005 SHALL have parameter ADDRW, default 11, graphic ROM address width.
REQ-006 SHALL have parameter ANIM_DIV, default 16, video frames per animation step (>=1).
REQ-007 SHALL have port clk, input, 1, pixel clock; one clock, all logic and the CPU bus synchronous to clk.
REQ-008 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have ports bus_cs, input, 1 and bus_write, input, 1: CPU select and write strobe.
REQ-010 SHALL have port bus_addr, input, 8: bits [7:2] are the slot index, bits [1:0] the register offset.
REQ-011 SHALL have ports bus_wdata, input, 16 and bus_rdata, output, 16: CPU write and read data.
REQ-012 SHALL have ports frame, input, 1 and line, input, 1: display-timing start-of-frame and start-of-line pulses.
REQ-013 SHALL have port sy, input, CORDW signed: current screen line.
REQ-014 SHALL have port spr_x, output, NUM_SPR x CORDW signed: active X per slot.
REQ-015 SHALL have port spr_start, output, NUM_SPR: per-slot line-start pulse.
REQ-016 SHALL have port spr_en, output, NUM_SPR: per-slot active enable.
REQ-017 SHALL have port spr_base, output, NUM_SPR x ADDRW: per-slot ROM base address.

Function
REQ-018 SHALL decode per-slot register offsets as: 0 = X, 1 = Y, 2 = CTRL {bit0 enable, bit1 autoanim, bits7:4 frame}, 3 = STATUS (read-only).
REQ-019 SHALL write the addressed pending register when bus_cs&&bus_write; writes to slot >= NUM_SPR or to STATUS SHALL be ignored.
REQ-020 SHALL clamp a written CTRL frame value >= NUM_FRAMES to NUM_FRAMES-1.
REQ-021 SHALL return bus_rdata one cycle after bus_cs&&!bus_write: offsets 0-2 return pending values; STATUS returns {12'h0, current active frame}; unmapped slots return 0.
REQ-022 SHALL copy every pending register to its active register on the cycle frame is high; outputs SHALL change only at frame boundaries.
REQ-023 SHALL, on a write coinciding with frame, commit the pre-write pending value and keep the new value pending until the next frame.
REQ-024 SHALL, on a CPU CTRL write of the frame field, reset that slot's animation divider and load the frame at the next commit.
REQ-025 SHALL, per slot with active autoanim, count frame pulses modulo ANIM_DIV and advance the active frame on the terminal count, wrapping NUM_FRAMES-1 -> 0.
REQ-026 SHALL drive spr_base = active_frame * SPR_PIXELS, registered, updated the cycle after the commit or advance.
REQ-027 SHALL assert spr_start[i] for exactly one cycle, the cycle after line is high, when sy equals active Y[i] and active enable[i] is set.
REQ-028 SHALL never assert spr_start for a disabled slot, and SHALL compare Y as a signed CORDW value, so negative Y never matches.

Reset
REQ-029 SHALL on rst zero all pending and active registers, animation dividers, bus_rdata, spr_x, spr_start, spr_en and spr_base.
REQ-030 SHALL give rst priority over frame, line and bus writes on the same cycle; a write during rst is lost.

Configuration
REQ-031 SHALL, with macro SPRITE_AUTOANIM_EN defined, implement REQ-025.
REQ-032 SHALL, without SPRITE_AUTOANIM_EN, omit the dividers, treat CTRL bit1 as reserved (reads 0), and change frames only by CPU write.

Structure
REQ-033 SHALL place register offsets, CTRL bit positions and a slot-register struct typedef in package sprite_engine_pkg.
REQ-034 SHALL instantiate sub-module sprite_slot once per slot (pending/active registers, divider, start compare); sprite_engine holds the bus decode and read mux.

Verification
REQ-035 SHALL cover: write X=100 to slot 0, no frame -> spr_x[0] stays 0; pulse frame -> spr_x[0]=100 next cycle.
REQ-036 SHALL cover: slot 1 Y=50 with enable set and committed; line with sy=50 -> spr_start[1] pulses once, one cycle later; sy=51 -> no pulse.
REQ-037 SHALL cover (SPRITE_AUTOANIM_EN defined, ANIM_DIV=2, NUM_FRAMES=3): autoanim on -> spr_base sequence 0, 640, 1280, 0 every 2 frames.
REQ-038 SHALL cover: CTRL frame=9 written -> STATUS reads 2 after commit, spr_base=1280.
REQ-039 SHALL cover: a write of Y=30 on the same cycle as frame -> old Y active, and Y=30 active after the following frame.
REQ-040 SHALL cover: rst asserted mid-animation with writes pending -> all outputs 0 next cycle, and reads of slot 9 return 0.
